pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 16, width of one operand lane.
REQ-002 Parameter N_OPS, default 6, number of operand lanes (op1, op2, op1_FWD, op2_FWD, sgn_EXT, ZRO_EXT).
REQ-003 Parameter CTRL_W, default 13, width of the packed control-signal bundle (regWrite through ALUop).
REQ-004 Parameter RD_W, default 4, width of the destination-register field.
REQ-005 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  discard all held entries; insert bubble.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage can accept this cycle.
REQ-011 in_ops  input  N_OPS*DATA_W  operand lanes, lane k at bits [k*DATA_W +: DATA_W].
REQ-012 in_ctrl  input  CTRL_W  control bundle.
REQ-013 in_rd  input  RD_W  destination register.
REQ-014 out_valid  output  1  entry presented downstream.
REQ-015 out_ready  input  1  downstream accepts this cycle.
REQ-016 out_ops / out_ctrl / out_rd  output  N_OPS*DATA_W / CTRL_W / RD_W  presented entry.
REQ-017 flush_out  output  1  registered flush indication, one cycle after flush.
REQ-018 count  output  2  entries held (0..2).

Function
REQ-019 Storage SHALL be two entries: main (drives outputs) and skid; each holds ops, ctrl, rd, valid bit.
REQ-020 Accept occurs when in_valid && in_ready at a rising edge; emit occurs when out_valid && out_ready.
REQ-021 in_ready SHALL equal !skid.valid && !rst, from registered state only (no combinational path from out_ready).
REQ-022 out_valid SHALL equal main.valid; out_ops/out_rd SHALL reflect main registers.
REQ-023 out_ctrl SHALL be all zeros whenever out_valid=0 (bubble never carries write/mem enables).
REQ-024 Accept with main empty, or main emitted same cycle with skid empty: entry loads main; out_valid next cycle (1-cycle latency).
REQ-025 Accept with main full and not emitted: entry loads skid.
REQ-026 Emit with skid full: skid moves to main, skid cleared; no accept possible that cycle.
REQ-027 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush/reset.
REQ-028 Sustained in_valid=1, out_ready=1 SHALL give one entry per cycle throughput.
REQ-029 out_ready=0 SHALL hold main contents stable; in_valid may be deasserted without effect on held entries.
REQ-030 flush=1 SHALL clear both valid bits and zero all stored ops/ctrl/rd next edge; same-cycle input is discarded; flush has priority over accept and emit.
REQ-031 flush_out SHALL be flush delayed one cycle; cleared by reset.
REQ-032 count SHALL equal main.valid + skid.valid.

Reset
REQ-033 rst=1 at an edge SHALL clear main, skid, valid bits, flush_out to 0; rst overrides flush and handshake.
REQ-034 While rst=1, in_ready=0, out_valid=0, out_ctrl=0, count=0; first accept possible on the first edge with rst=0.
REQ-035 Reset mid-transfer SHALL discard held entries without emitting them.

Verification
REQ-036 Reset then single entry ops lane0=16'h1234, ctrl=13'h1FFF, rd=4'hA, out_ready=1 -> next cycle out_valid=1, outputs match, count=1; following cycle out_valid=0, out_ctrl=0.
REQ-037 Stream 8 entries back-to-back, out_ready=1 -> 8 consecutive out_valid cycles, order preserved, in_ready stays 1.
REQ-038 out_ready=0, push A then B -> count=2, in_ready=0, out shows A; raise out_ready -> A then B emitted on consecutive cycles.
REQ-039 count=2, flush=1 with in_valid=1 (entry C) -> next cycle count=0, out_valid=0, out_ctrl=0, flush_out=1; C never emitted.
REQ-040 count=2, rst=1 for one cycle -> all outputs zero, in_ready=0 during reset, 1 after; no held entry emitted.
REQ-041 Random in_valid/out_ready 10k cycles vs. FIFO scoreboard -> zero mismatches, count never exceeds 2.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between the upstream producer, the skid stage and the downstream consumer.
// Member names keep the original port names so existing hookups map one-to-one.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 16,
  parameter int N_OPS  = 6,
  parameter int CTRL_W = 13,
  parameter int RD_W   = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OPS*DATA_W-1:0] in_ops;
  logic [CTRL_W-1:0]       in_ctrl;
  logic [RD_W-1:0]         in_rd;

  logic                    out_valid;
  logic                    out_ready;
  logic [N_OPS*DATA_W-1:0] out_ops;
  logic [CTRL_W-1:0]       out_ctrl;
  logic [RD_W-1:0]         out_rd;

  // Environment side: drives the upstream entry and the downstream ready.
  modport master (
    output in_valid, in_ops, in_ctrl, in_rd, out_ready,
    input  in_ready, out_valid, out_ops, out_ctrl, out_rd
  );

  // Stage side.
  modport slave (
    input  in_valid, in_ops, in_ctrl, in_rd, out_ready,
    output in_ready, out_valid, out_ops, out_ctrl, out_rd
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline register stage carrying operand lanes, control bundle and rd.
// in_ready depends only on registered occupancy and rst, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
  parameter int DATA_W = 16,
  parameter int N_OPS  = 6,
  parameter int CTRL_W = 13,
  parameter int RD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_skid_stage_if.slave     bus,
  output logic                 flush_out,
  output logic [1:0]           count
);

  localparam int OPS_W = N_OPS * DATA_W;

  // Occupancy doubles as the main/skid valid bits: skid can only be full while main is full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } occ_e;

  occ_e              r_state;
  occ_e              w_state_nxt;

  logic [OPS_W-1:0]  r_main_ops;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [RD_W-1:0]   r_main_rd;
  logic [OPS_W-1:0]  r_skid_ops;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [RD_W-1:0]   r_skid_rd;
  logic              r_flush_out;

  logic w_main_valid;
  logic w_skid_valid;
  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_emit;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clear_all;

  always_comb begin
    w_main_valid     = (r_state != ST_EMPTY);
    w_skid_valid     = (r_state == ST_BOTH);
    w_in_ready       = !w_skid_valid && !rst;
    w_out_valid      = w_main_valid && !rst;
    w_accept         = bus.in_valid && w_in_ready;
    w_emit           = w_out_valid && bus.out_ready;
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear_all      = 1'b0;

    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_clear_all = 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ST_MAIN;
          end
        end
        ST_MAIN: begin
          // Emit + accept in the same cycle refills main directly: one entry per cycle.
          if (w_accept && w_emit) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_BOTH;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_BOTH: begin
          if (w_emit) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ST_MAIN;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_clear_all = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear_all) begin
      r_main_ops  <= '0;
      r_main_ctrl <= '0;
      r_main_rd   <= '0;
      r_skid_ops  <= '0;
      r_skid_ctrl <= '0;
      r_skid_rd   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ops  <= bus.in_ops;
        r_main_ctrl <= bus.in_ctrl;
        r_main_rd   <= bus.in_rd;
      end else if (w_load_main_skid) begin
        r_main_ops  <= r_skid_ops;
        r_main_ctrl <= r_skid_ctrl;
        r_main_rd   <= r_skid_rd;
      end
      if (w_load_skid) begin
        r_skid_ops  <= bus.in_ops;
        r_skid_ctrl <= bus.in_ctrl;
        r_skid_rd   <= bus.in_rd;
      end else if (w_load_main_skid) begin
        r_skid_ops  <= '0;
        r_skid_ctrl <= '0;
        r_skid_rd   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_out <= 1'b0;
    end else begin
      r_flush_out <= flush;
    end
  end

  // Bubbles must never carry write/mem enables, so ctrl is masked by valid.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ops   = r_main_ops;
  assign bus.out_rd    = r_main_rd;
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign flush_out     = r_flush_out;
  assign count         = rst ? 2'd0 : {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
